modadd_accum_seq: RTL and testbench
===================================

# modadd_accum_seq

Sequencer that turns the one-stage 3-input partial-modular adder (ModAdd_3x2_FF) into a streaming modular accumulator. It accepts a burst of `len` residue operands on a valid/ready stream and drives the adder's `in_a/in_b/in_c` with operand plus fed-back `lut_sum`/`trunc_sum`. It then runs fixed fold passes and presents the final partial-form pair on a held result handshake. The adder instance stays outside this block; a tile-level wrapper pairs one controller with one adder per RNS digit lane.

## Interface
- `DATA_WIDTH`, default 18: adder operand width; the residue field is `DATA_WIDTH-2` bits.
- `CNT_WIDTH`, default 8: width of the burst-length counter.
- `FOLD_CYCLES`, default 2: zero-operand fold passes after the last beat; legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `len` in CNT_WIDTH: operand count, sampled with `start`.
- `in_valid` in 1: operand valid.
- `in_data` in DATA_WIDTH: operand, must be < 2^(DATA_WIDTH-2); not checked.
- `in_ready` out 1: operand accept.
- `dp_a`, `dp_b`, `dp_c` out DATA_WIDTH: drive the adder's `in_a`, `in_b`, `in_c`.
- `dp_lut` in DATA_WIDTH: adder `lut_sum`.
- `dp_trunc` in DATA_WIDTH-2: adder `trunc_sum`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accept.
- `res_lut` out DATA_WIDTH: registered `lut_sum` capture.
- `res_trunc` out DATA_WIDTH-2: registered `trunc_sum` capture.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States are IDLE, ACCUM, FOLD, CAPT, DONE.
- **IDLE**
  - `start` with `len`≠0 goes to ACCUM, loads `cnt=len`, clears `primed`.
  - `start` with `len`=0 goes to DONE with `res_lut=0` and `res_trunc=0`.
- **ACCUM**
  - `in_ready=1`.
  - `dp_a = in_valid ? in_data : 0`.
  - On each beat (`in_valid & in_ready`): decrement `cnt` and set `primed`.
  - A beat with `cnt==1` goes to FOLD and loads `fold_cnt=FOLD_CYCLES`.
- **Feedback**
  - `dp_b = primed ? dp_lut : 0`.
  - `dp_c = primed ? {2'b0,dp_trunc} : 0`.
  - Before the first beat, feedback is masked because the adder outputs are stale.
- **Stall**: `in_valid` low in ACCUM adds zero, which preserves the residue. No operand is lost or duplicated.
- **FOLD**: `dp_a=0` with feedback; decrement `fold_cnt`; at 1, go to CAPT.
- **CAPT**
  - `dp_a=0` with feedback.
  - At the clock edge: `res_lut<=dp_lut`, `res_trunc<=dp_trunc`, `res_valid<=1`, go to DONE.
- **DONE**
  - `res_*` are held stable while `res_valid & !res_ready`.
  - On accept, `res_valid<=0` and the state goes to IDLE.
  - The datapath keeps a zero-add.
- **Ignored inputs**: `start` outside IDLE is ignored; `in_valid` outside ACCUM is ignored because `in_ready=0`.
- **Result format**: the result is partial form. `(res_lut + res_trunc) mod M` equals the sum of the operands mod M, and downstream performs the final add.
- **Widths**: `dp_c` is always zero-extended by 2 bits. No arithmetic is done in this block beyond the counters.

## Timing
- **Reset values**: state IDLE; `in_ready`, `res_valid`, `busy` = 0; `res_lut`, `res_trunc` = 0; `cnt`, `fold_cnt`, `primed` = 0.
  - `dp_*` = 0 because IDLE drives zero and `primed=0`.
- **Reset mid-burst**: aborts immediately to IDLE; no result is produced.
- **Start**: `start` in cycle s gives `busy` and `in_ready` high in s+1.
- **Throughput**: one operand per cycle while `in_valid` is held; the adder feedback latency is exactly 1 cycle.
- **Result latency**: with the last beat in cycle t, `res_valid` rises in cycle t+FOLD_CYCLES+2.
  - With the default of 2, that is t+4.
- **Zero length**: `len`=0 gives `res_valid` high in s+1.
- **Back-to-back**: `res_ready` in cycle r gives IDLE in r+1. The earliest next `start` is sampled in r+1.

## Structure
- `modadd_ctrl_pkg` holds:
  - `state_t` enum (IDLE, ACCUM, FOLD, CAPT, DONE);
  - `FOLD_CYCLES_DEF`;
  - helper function `zext2()` for the `dp_c` extension.
- No sub-module; a single FSM plus two down-counters.
- The bench uses a behavioural adder model: 1-cycle registered, LUT returns `(adr·2^16) mod M`, with M=65521.

## Test plan
1. `len=3`, operands 65520, 65520, 5 back-to-back -> `res_valid` at t+4; `(res_lut+res_trunc) mod 65521 = 3`.
2. `len=4`, operands 1, 2, 3, 4 with `in_valid` low for 3 cycles between beats 2 and 3 -> result ≡10; `in_ready` stays 1 throughout ACCUM.
3. `len=0` -> `res_valid=1` one cycle after `start`, `res_lut=0`, `res_trunc=0`, no `in_ready` pulse.
4. `res_ready` held low for 5 cycles -> `res_*` stable; `start` pulsed during DONE is ignored; `busy=1` until the cycle after accept.
5. `reset_n` asserted after 2 of 5 beats -> all outputs return to reset values asynchronously; a fresh `len=1`, operand 7 burst then yields ≡7 with no stale feedback.
6. 200 random bursts (`len` 1..255, random `in_valid`/`res_ready` gaps) -> every result matches a scoreboard sum mod 65521.

Source files
------------

// File: rtl/modadd_ctrl_pkg.sv
// Shared types and helpers for the modular-accumulator sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package modadd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FOLD  = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Zero-operand passes run after the last beat so the partial form settles.
  localparam int FOLD_CYCLES_DEF = 2;

  // Fold counter must hold the largest legal fold count (15).
  localparam int FOLD_CNT_W = 4;

  // Widest operand zext2() can handle; callers cast down to DATA_WIDTH.
  localparam int ZEXT_MAX_W = 64;

  // Widens the adder's truncated sum back to operand width for the c input.
  function automatic logic [ZEXT_MAX_W-1:0] zext2(input logic [ZEXT_MAX_W-3:0] v);
    return {2'b00, v};
  endfunction

endpackage

// File: rtl/modadd_accum_seq.sv
// Streams a burst of residues through an external 1-cycle 3-input partial-modular
// adder, feeding its lut/trunc outputs back, then folds and captures the result.
// Latency: last beat in cycle t -> res_valid in t+FOLD_CYCLES+2; len=0 -> result next cycle.
// Backpressure: in_ready is high for the whole burst (stalls add zero); the result is
// held stable on res_* until res_ready.
// Ports: clk/reset_n; start/len request; in_valid/in_ready/in_data operand stream;
// dp_a/dp_b/dp_c to the adder, dp_lut/dp_trunc from it; res_valid/res_ready/res_lut/
// res_trunc result; busy = not IDLE.
module modadd_accum_seq
  import modadd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int CNT_WIDTH   = 8,
  parameter int FOLD_CYCLES = FOLD_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] dp_a,
  output logic [DATA_WIDTH-1:0] dp_b,
  output logic [DATA_WIDTH-1:0] dp_c,
  input  logic [DATA_WIDTH-1:0] dp_lut,
  input  logic [DATA_WIDTH-3:0] dp_trunc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_lut,
  output logic [DATA_WIDTH-3:0] res_trunc,
  output logic                  busy
);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [FOLD_CNT_W-1:0]   fold_cnt_q, fold_cnt_d;
  logic                    primed_q, primed_d;
  logic                    res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0]   res_lut_q, res_lut_d;
  logic [DATA_WIDTH-3:0]   res_trunc_q, res_trunc_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fold_cnt_d  = fold_cnt_q;
    primed_d    = primed_q;
    res_valid_d = res_valid_q;
    res_lut_d   = res_lut_q;
    res_trunc_d = res_trunc_q;
    dp_a        = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d  = ACCUM;
            cnt_d    = len;
            // Adder outputs still hold the previous burst; mask them until our first beat.
            primed_d = 1'b0;
          end else begin
            state_d     = DONE;
            res_lut_d   = '0;
            res_trunc_d = '0;
            res_valid_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        // in_ready is constantly high here, so in_valid alone marks a beat.
        if (in_valid) begin
          dp_a     = in_data;
          cnt_d    = cnt_q - CNT_WIDTH'(1);
          primed_d = 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d    = FOLD;
            fold_cnt_d = FOLD_CNT_W'(FOLD_CYCLES);
          end
        end
      end
      FOLD: begin
        fold_cnt_d = fold_cnt_q - FOLD_CNT_W'(1);
        if (fold_cnt_q == FOLD_CNT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        res_lut_d   = dp_lut;
        res_trunc_d = dp_trunc;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Feedback closes the accumulation loop through the adder's output register.
  assign dp_b = primed_q ? dp_lut : '0;
  assign dp_c = primed_q ? DATA_WIDTH'(zext2((ZEXT_MAX_W-2)'(dp_trunc))) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fold_cnt_q  <= '0;
      primed_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_lut_q   <= '0;
      res_trunc_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fold_cnt_q  <= fold_cnt_d;
      primed_q    <= primed_d;
      res_valid_q <= res_valid_d;
      res_lut_q   <= res_lut_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_lut   = res_lut_q;
  assign res_trunc = res_trunc_q;

endmodule

// File: tb/tb_modadd_accum_seq.sv
// Bench for modadd_accum_seq with a behavioural 1-cycle partial-modular adder (M=65521).
// Latency: checks result timing t+FOLD_CYCLES+2 and len=0 timing s+1.
// Backpressure: drives in_valid gaps and res_ready holds; scoreboard compares on accept.
module tb_modadd_accum_seq;

  localparam int DW = 18;
  localparam int CW = 8;
  localparam int FC = 2;
  localparam int unsigned M = 65521;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] dp_a, dp_b, dp_c;
  logic [DW-1:0] dp_lut = '0;
  logic [DW-3:0] dp_trunc = '0;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_lut;
  logic [DW-3:0] res_trunc;
  logic          busy;

  always #5 clk = ~clk;

  modadd_accum_seq #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FOLD_CYCLES(FC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_c      (dp_c),
    .dp_lut    (dp_lut),
    .dp_trunc  (dp_trunc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_lut   (res_lut),
    .res_trunc (res_trunc),
    .busy      (busy)
  );

  // Behavioural adder: sum split at bit 16; bits above 16 folded through the LUT.
  // Deliberately not reset, so stale contents survive a controller reset.
  logic [19:0] add_sum;
  assign add_sum = 20'(dp_a) + 20'(dp_b) + 20'(dp_c);

  function automatic logic [17:0] lut_f(input logic [3:0] adr);
    int unsigned v;
    v = (32'(adr) * 32'd65536) % M;
    return v[17:0];
  endfunction

  always @(posedge clk) begin
    dp_lut   <= lut_f(add_sum[19:16]);
    dp_trunc <= add_sum[15:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int unsigned exp_q[$];
  int unsigned ops_q[$];
  int          gaps_q[$];
  int unsigned sb_e;

  // Scoreboard: compare on each accepted result, sampled after the drive point.
  always @(negedge clk) begin
    #1;
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_result", (32'(res_lut) + 32'(res_trunc)) % M, sb_e);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Runs one burst from ops_q/gaps_q; result held rdy_gap cycles before accept.
  task automatic run_burst(input int rdy_gap, input bit poke_start);
    int          n;
    int unsigned acc;
    logic [DW-1:0] pl;
    logic [DW-3:0] pt;
    acc = 0;
    foreach (ops_q[i]) acc = (acc + ops_q[i]) % M;
    exp_q.push_back(acc);
    cyc();
    start = 1'b1;
    len   = CW'(ops_q.size());
    cyc();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("rdy_after_start", 32'(in_ready), 32'd1);
    foreach (ops_q[i]) begin
      repeat (gaps_q[i]) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        chk("rdy_stall", 32'(in_ready), 32'd1);
        cyc();
      end
      chk("rdy_beat", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = DW'(ops_q[i]);
      cyc();
    end
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    // Now in cycle t+1; track model outputs so the CAPT-cycle values are known.
    n  = 1;
    pl = dp_lut;
    pt = dp_trunc;
    while (!res_valid && n < 300) begin
      pl = dp_lut;
      pt = dp_trunc;
      cyc();
      n++;
    end
    chk("res_latency", 32'(n), 32'(FC + 2));
    chk("res_lut_capt", 32'(res_lut), 32'(pl));
    chk("res_trunc_capt", 32'(res_trunc), 32'(pt));
    for (int k = 0; k < rdy_gap; k++) begin
      res_ready = 1'b0;
      if (poke_start && k == 0) begin
        start = 1'b1;
        len   = CW'(3);
      end
      cyc();
      start = 1'b0;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_lut", 32'(res_lut), 32'(pl));
      chk("hold_trunc", 32'(res_trunc), 32'(pt));
    end
    chk("busy_at_accept", 32'(busy), 32'd1);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd0);
    chk("valid_after_accept", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_lut", 32'(res_lut), 32'd0);
    chk("rst_res_trunc", 32'(res_trunc), 32'd0);
    chk("rst_dp_a", 32'(dp_a), 32'd0);
    chk("rst_dp_b", 32'(dp_b), 32'd0);
    chk("rst_dp_c", 32'(dp_c), 32'd0);
    reset_n = 1'b1;

    // Wrap-around operands, back-to-back.
    ops_q = '{65520, 65520, 5};
    gaps_q = '{0, 0, 0};
    run_burst(0, 1'b0);

    // Stall of 3 cycles between beats 2 and 3, random junk on in_data meanwhile.
    ops_q = '{1, 2, 3, 4};
    gaps_q = '{0, 0, 3, 0};
    run_burst(1, 1'b0);

    // Zero-length request.
    exp_q.push_back(0);
    cyc();
    chk("len0_rdy_s", 32'(in_ready), 32'd0);
    start = 1'b1;
    len   = '0;
    cyc();
    start = 1'b0;
    chk("len0_valid", 32'(res_valid), 32'd1);
    chk("len0_lut", 32'(res_lut), 32'd0);
    chk("len0_trunc", 32'(res_trunc), 32'd0);
    chk("len0_rdy", 32'(in_ready), 32'd0);
    chk("len0_busy", 32'(busy), 32'd1);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("len0_idle", 32'(busy), 32'd0);

    // Long result hold with a start pulse during DONE.
    ops_q = '{40000, 50000};
    gaps_q = '{0, 1};
    run_burst(5, 1'b1);

    // Reset after 2 of 5 beats.
    cyc();
    start = 1'b1;
    len   = CW'(5);
    cyc();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(11);
    cyc();
    in_data  = DW'(22);
    cyc();
    in_data  = DW'(33);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_dp_a", 32'(dp_a), 32'd0);
    chk("arst_dp_b", 32'(dp_b), 32'd0);
    chk("arst_dp_c", 32'(dp_c), 32'd0);
    in_valid = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    ops_q = '{7};
    gaps_q = '{0};
    run_burst(0, 1'b0);

    // Random bursts.
    for (int b = 0; b < 200; b++) begin
      int l;
      l = $urandom_range(1, 255);
      ops_q.delete();
      gaps_q.delete();
      for (int i = 0; i < l; i++) begin
        ops_q.push_back($urandom_range(0, 65535));
        gaps_q.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_burst($urandom_range(0, 3), 1'b0);
    end

    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
